// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined ALU barrel shifter: mode encodings and per-stage control payload.
// Rotate-right support is enabled by defining SHIFT_PIPE_ROR_EN.
package shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  // Width-independent part of the stage payload; data, shamt and tag are
  // parameter-sized vectors and therefore live beside this struct.
  typedef struct packed {
    logic       valid;
    logic       enable;
    logic [1:0] mode;
    logic       sign;
  } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by DIST followed by the payload register.
// ALUfun=10 rotates right when SHIFT_PIPE_ROR_EN is defined, otherwise it shifts arithmetically.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DIST  = 1,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  input  stage_ctrl_t      in_ctrl,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic [TAG_W-1:0] out_tag,
  output stage_ctrl_t      out_ctrl
);

  localparam int K = $clog2(DIST);

  logic             do_shift;
  logic [WIDTH-1:0] shifted;

  logic [WIDTH-1:0] data_reg;
  logic [SHW-1:0]   shamt_reg;
  logic [TAG_W-1:0] tag_reg;
  stage_ctrl_t      ctrl_reg;

  assign do_shift = in_ctrl.enable & in_shamt[K];

  // Arithmetic fill uses the sign captured at acceptance, not the current MSB.
  always_comb begin
    shifted = in_data;
    if (do_shift) begin
      case (in_ctrl.mode)
        MODE_SLL: shifted = {in_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
        MODE_SRL: shifted = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
`ifdef SHIFT_PIPE_ROR_EN
        MODE_ROR: shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
        MODE_SRA: shifted = {{DIST{in_ctrl.sign}}, in_data[WIDTH-1:DIST]};
`else
        MODE_ROR,
        MODE_SRA: shifted = {{DIST{in_ctrl.sign}}, in_data[WIDTH-1:DIST]};
`endif
        default:  shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      shamt_reg <= '0;
      tag_reg   <= '0;
      ctrl_reg  <= '0;
    end else if (load) begin
      data_reg  <= shifted;
      shamt_reg <= in_shamt;
      tag_reg   <= in_tag;
      ctrl_reg  <= in_ctrl;
    end
  end

  assign out_data  = data_reg;
  assign out_shamt = shamt_reg;
  assign out_tag   = tag_reg;
  assign out_ctrl  = ctrl_reg;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA, optional ROR via SHIFT_PIPE_ROR_EN),
// one register stage per shift-amount bit, LSB distance first, with valid/ready handshakes.
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       ALUfun,
  input  logic             enable,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [TAG_W-1:0] out_tag
);

  // Index 0 is the accepted input; index gi+1 is the register of stage gi.
  logic [WIDTH-1:0] data_pipe  [0:SHW];
  logic [SHW-1:0]   shamt_pipe [0:SHW];
  logic [TAG_W-1:0] tag_pipe   [0:SHW];
  stage_ctrl_t      ctrl_pipe  [0:SHW];

  logic advance;
  logic unused_tail;

  // The whole pipe moves as one; bubbles are carried, never collapsed.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  assign data_pipe[0]  = B;
  assign shamt_pipe[0] = shamt;
  assign tag_pipe[0]   = in_tag;
  assign ctrl_pipe[0]  = '{valid: in_valid, enable: enable, mode: ALUfun, sign: B[WIDTH-1]};

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << gi),
        .TAG_W (TAG_W)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (advance),
        .in_data   (data_pipe[gi]),
        .in_shamt  (shamt_pipe[gi]),
        .in_tag    (tag_pipe[gi]),
        .in_ctrl   (ctrl_pipe[gi]),
        .out_data  (data_pipe[gi+1]),
        .out_shamt (shamt_pipe[gi+1]),
        .out_tag   (tag_pipe[gi+1]),
        .out_ctrl  (ctrl_pipe[gi+1])
      );
    end
  endgenerate

  assign y         = data_pipe[SHW];
  assign out_tag   = tag_pipe[SHW];
  assign out_valid = ctrl_pipe[SHW].valid;

  // Control fields of the final stage have no consumer.
  assign unused_tail = ^{shamt_pipe[SHW], ctrl_pipe[SHW].enable,
                         ctrl_pipe[SHW].mode, ctrl_pipe[SHW].sign};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vector table, streaming scoreboard,
// backpressure and mid-stream reset sequences. ROR expectations follow SHIFT_PIPE_ROR_EN.
module tb_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW   = 5;
  localparam int NVEC  = 14;

`ifdef SHIFT_PIPE_ROR_EN
  localparam logic [31:0] ROR1_EXP = 32'h1000_0000;
  localparam logic [31:0] ROR2_EXP = 32'hAB00_0000;
`else
  localparam logic [31:0] ROR1_EXP = 32'h0000_0000;
  localparam logic [31:0] ROR2_EXP = 32'h0000_0000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  B;
  logic [SHW-1:0]    shamt;
  logic [1:0]        ALUfun;
  logic              enable;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  y;
  logic [TAG_W-1:0]  out_tag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] b;
    logic [4:0]  sh;
    logic [1:0]  fun;
    logic        en;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t ops_q [$];
  bit   rdy_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .B         (B),
    .shamt     (shamt),
    .ALUfun    (ALUfun),
    .enable    (enable),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference built from whole-word shift operators.
  function automatic logic [31:0] model(input logic [31:0] b, input logic [4:0] s,
                                        input logic [1:0] f, input logic en);
    logic [31:0] r;
    if (!en) return b;
    case (f)
      2'b00: r = b << s;
      2'b01: r = b >> s;
`ifdef SHIFT_PIPE_ROR_EN
      2'b10: r = (s == 5'd0) ? b : ((b >> s) | (b << (32 - int'(s))));
`else
      2'b10: r = 32'($signed(b) >>> s);
`endif
      default: r = 32'($signed(b) >>> s);
    endcase
    return r;
  endfunction

  task automatic set_in(input vec_t v);
    B      = v.b;
    shamt  = v.sh;
    ALUfun = v.fun;
    enable = v.en;
    in_tag = v.tag;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int acc;
    int waited;
    @(negedge clk);
    set_in(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    B        = $urandom;
    shamt    = 5'($urandom);
    waited   = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_latency"}, 32'(cyc - acc), 32'd5);
    chk({nm, "_y"}, y, v.exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(v.tag));
    $display("%s B=%h shamt=%0d fun=%b en=%b -> y=%h tag=%0d lat=%0d",
             nm, v.b, v.sh, v.fun, v.en, y, out_tag, cyc - acc);
  endtask

  // Drives ops_q with per-cycle out_ready from rdy_q and scoreboards every output handshake.
  task automatic run_stream(input string nm, output int first_out, output int last_out,
                            output int n_out);
    vec_t        exp_q [$];
    vec_t        e;
    int          si;
    bit          prev_stall;
    logic [31:0] py;
    logic [3:0]  pt;
    si = 0; prev_stall = 0; py = '0; pt = '0;
    n_out = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      out_ready = (i < rdy_q.size()) ? rdy_q[i] : 1'b1;
      if (si < ops_q.size()) begin
        set_in(ops_q[si]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_hold_y"}, y, py);
        chk({nm, "_hold_tag"}, 32'(out_tag), 32'(pt));
      end
      if (out_valid && !out_ready)
        chk({nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_unexpected_out"}, 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_y"}, y, e.exp);
          chk({nm, "_tag"}, 32'(out_tag), 32'(e.tag));
          $display("%s out tag=%0d y=%h exp=%h cyc=%0d", nm, out_tag, y, e.exp, cyc);
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      py = y;
      pt = out_tag;
      if (in_valid && in_ready) begin
        e = ops_q[si];
        e.exp = model(e.b, e.sh, e.fun, e.en);
        exp_q.push_back(e);
        si++;
      end
      if (si == ops_q.size() && exp_q.size() == 0) break;
    end
    chk({nm, "_drained"}, 32'(exp_q.size() + (ops_q.size() - si)), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int fo, lo, no;
    int ghosts;
    vec_t v;

    vecs[0]  = '{32'h0000_00F1, 5'd4,  2'b00, 1'b1, 4'h1, 32'h0000_0F10};
    vecs[1]  = '{32'h8000_0010, 5'd31, 2'b11, 1'b1, 4'h2, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h8000_0010, 5'd31, 2'b01, 1'b1, 4'h3, 32'h0000_0001};
    vecs[3]  = '{32'h8000_0010, 5'd7,  2'b11, 1'b0, 4'h4, 32'h8000_0010};
    vecs[4]  = '{32'h0000_0003, 5'd31, 2'b00, 1'b1, 4'h5, 32'h8000_0000};
    vecs[5]  = '{32'h8000_0001, 5'd0,  2'b11, 1'b1, 4'h6, 32'h8000_0001};
    vecs[6]  = '{32'hF000_0000, 5'd4,  2'b11, 1'b1, 4'h7, 32'hFF00_0000};
    vecs[7]  = '{32'hF000_0000, 5'd4,  2'b01, 1'b1, 4'h8, 32'h0F00_0000};
    vecs[8]  = '{32'h1234_5678, 5'd8,  2'b00, 1'b1, 4'h9, 32'h3456_7800};
    vecs[9]  = '{32'h8000_0000, 5'd1,  2'b11, 1'b1, 4'hA, 32'hC000_0000};
    vecs[10] = '{32'h8000_00FF, 5'd3,  2'b11, 1'b1, 4'hB, 32'hF000_001F};
    vecs[11] = '{32'h0000_0001, 5'd4,  2'b10, 1'b1, 4'hC, ROR1_EXP};
    vecs[12] = '{32'h0000_00AB, 5'd8,  2'b10, 1'b1, 4'hD, ROR2_EXP};
    vecs[13] = '{32'h8000_0010, 5'd17, 2'b01, 1'b1, 4'hE, 32'h0000_4000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    B = '0; shamt = '0; ALUfun = 2'b00; enable = 1'b1; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_y", y, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: eight operations, tags 0..7, consumer always ready.
    ops_q.delete(); rdy_q.delete();
    for (int i = 0; i < 8; i++) begin
      v.b   = 32'h8765_4321 ^ (32'(i) * 32'h1111_1111);
      v.sh  = 5'((i * 5 + 3) % 32);
      v.fun = 2'(i % 4);
      v.en  = (i != 6);
      v.tag = 4'(i);
      v.exp = '0;
      ops_q.push_back(v);
    end
    run_stream("b2b", fo, lo, no);
    chk("b2b_count", 32'(no), 32'd8);
    chk("b2b_consecutive", 32'(lo - fo), 32'd7);

    // Backpressure: consumer stalls three cycles once results start to flow.
    ops_q.delete(); rdy_q.delete();
    for (int i = 0; i < 10; i++) begin
      v.b   = 32'hC3A5_0F96 + 32'(i * 32'h0101_0101);
      v.sh  = 5'((i * 7 + 1) % 32);
      v.fun = 2'((i + 1) % 4);
      v.en  = 1'b1;
      v.tag = 4'(i + 3);
      v.exp = '0;
      ops_q.push_back(v);
    end
    rdy_q = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    run_stream("bp", fo, lo, no);
    chk("bp_count", 32'(no), 32'd10);

    // Reset with one result at the output and four more in flight.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = '{32'h0000_0F0F, 5'(i + 1), 2'b00, 1'b1, 4'(9 + i), 32'h0};
      set_in(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    chk("rst_pre_tag", 32'(out_tag), 32'd9);
    chk("rst_pre_y", y, 32'h0000_1E1E);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    ghosts = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) ghosts++;
      @(negedge clk);
    end
    chk("rst_no_ghosts", 32'(ghosts), 32'd0);
    $display("reset mid-stream: ghosts=%0d", ghosts);
    run_vec("post_rst", '{32'h0000_00F1, 5'd4, 2'b00, 1'b1, 4'hF, 32'h0000_0F10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
